matrix_load_64: RTL and testbench
=================================

Name: matrix_load_64

Overview:
Upstream stage of the 64x64 column-block selector in the PE1X64_64X64 datapath.
- Accepts a 64x64 signed 16-bit matrix one row per beat over a valid/ready stream.
- Assembles the rows into one flat 65536-bit register.
- Presents the full matrix with a level valid, held until the consumer acknowledges.
- mat_valid drives the selector's en; mat_ack comes from the selector's finish path.

Parameters:
- N, 64, matrix dimension (rows = columns = beats per frame).
- DATA_W, 16, element width in bits, signed two's complement.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_row/in_last valid this cycle.
- in_ready  output  1  block can accept a row this cycle.
- in_row  input  N*DATA_W (1024)  one row; element c at in_row[N*DATA_W-1-DATA_W*c -: DATA_W].
- in_last  input  1  producer marks final row of frame.
- Matrix  output  N*N*DATA_W (65536)  assembled matrix, signed.
- mat_valid  output  1  Matrix complete and stable.
- mat_ack  input  1  consumer has taken Matrix.
- row_cnt  output  6  rows accepted in the current frame (0..63).
- frame_err  output  1  sticky in_last framing error.

Behaviour:
- Reset (rst=1 at posedge): Matrix=0, mat_valid=0, row_cnt=0, frame_err=0, state=LOAD. rst has priority over all other inputs.
- Power-up initial values equal the reset values.
- States: LOAD, FULL.
- in_ready = (state==LOAD) && !rst. It is combinational from state only, never from in_valid.
- Beat accepted when in_valid && in_ready at posedge.
- In LOAD, an accepted beat writes row r=row_cnt into Matrix[N*N*DATA_W-1-N*DATA_W*r -: N*DATA_W]. Row 0 is at the MSBs. All other bits hold.
- row_cnt increments by 1 per accepted beat.
- Accepted beat with row_cnt==N-1:
  - row written, row_cnt wraps to 0, state->FULL, mat_valid=1 next cycle.
  - Latency: mat_valid rises 1 cycle after the 64th accepted beat.
- in_last check on each accepted beat:
  - frame_err set if in_last=1 with row_cnt!=N-1, or in_last=0 with row_cnt==N-1.
  - Frame length is governed by the counter only; in_last never ends or extends a frame.
  - frame_err clears only on rst.
- FULL:
  - in_ready=0, Matrix frozen, mat_valid=1.
  - in_valid is ignored; the producer must hold the row.
- mat_ack in FULL: mat_valid=0 next cycle, state->LOAD. in_ready=1 in that following cycle; no beat is accepted in the ack cycle itself.
- Matrix is not cleared on ack. It holds the old contents until overwritten row-by-row.
- mat_ack in LOAD: ignored.
- in_valid with in_ready=0: no effect.
- Reset mid-frame: partial rows discarded, row_cnt=0, Matrix=0.
- Throughput: one frame per N+1 cycles minimum (64 beats + 1 ack cycle) when the consumer acks immediately.

Optional Feature:
Macro LOAD_TRANSPOSE_EN.
- Defined: beat r is written as column r. Element c of in_row goes to the Matrix element at row c, column r. Every other behaviour is unchanged (handshake, counter, latency, frame_err).
- Undefined: row-major write as above. No transpose logic is synthesised.

Test Plan:
- Reset then 64 back-to-back beats, row r all elements = r+1, in_last on beat 63, mat_ack=0 -> mat_valid=1 exactly 1 cycle after beat 63; Matrix[65535:65520]=16'h0001; Matrix[15:0]=16'h0040; in_ready=0; frame_err=0; row_cnt=0.
- Hold in FULL for 10 cycles with in_valid=1, in_row=16'hFFFF pattern -> Matrix unchanged, no beats accepted. Pulse mat_ack -> mat_valid=0 next cycle, in_ready=1.
- Random in_valid gaps (50% duty) over one frame -> mat_valid rises only after the 64th accepted beat; row_cnt tracks accepted beats exactly.
- in_last=1 on beat 10 and in_last=0 on beat 63 -> frame_err=1 from the cycle after beat 10; frame still completes at beat 63; frame_err stays 1 after ack until rst.
- rst asserted after 30 beats -> next cycle Matrix=0, row_cnt=0, mat_valid=0. A fresh 64-beat frame then completes normally.
- With LOAD_TRANSPOSE_EN, beat r element c = 16'h(r*64+c) -> element at row i, column j of Matrix = 16'h(j*64+i). Check signed element -1 (16'hFFFF) lands at row 5, column 7 when beat 7 element 5 = 16'hFFFF.

Source files
------------

// File: rtl/matrix_load_64.sv
// matrix_load_64: upstream stage of the 64x64 column-block selector.
// Collects an NxN signed DATA_W-bit matrix one row per valid/ready beat into a
// flat register. It then presents that register with a level valid until the
// consumer acknowledges it.
//
// Optional feature macro: LOAD_TRANSPOSE_EN
//   defined   -> beat r is written as column r (element c -> row c, col r)
//   undefined -> beat r is written as row r (row 0 at the MSBs)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over all inputs)
//   in_valid   in_row/in_last valid this cycle
//   in_ready   block can accept a row (combinational from state and rst)
//   in_row     one row; element c at in_row[N*DATA_W-1-DATA_W*c -: DATA_W]
//   in_last    producer's end-of-frame marker (checked only, never acted on)
//   Matrix     assembled matrix, element (i,j) at
//              [N*N*DATA_W-1-DATA_W*(i*N+j) -: DATA_W]
//   mat_valid  Matrix complete and stable
//   mat_ack    consumer has taken Matrix
//   row_cnt    rows accepted in the current frame
//   frame_err  sticky in_last framing error
module matrix_load_64 #(
  parameter int unsigned N      = 64,
  parameter int unsigned DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*DATA_W-1:0]        in_row,
  input  logic                       in_last,
  output logic [N*N*DATA_W-1:0]      Matrix,
  output logic                       mat_valid,
  input  logic                       mat_ack,
  output logic [$clog2(N)-1:0]       row_cnt,
  output logic                       frame_err
);

  localparam int unsigned CNT_W = $clog2(N);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   mat_valid_nxt;
  logic   frame_err_nxt;
  logic [CNT_W-1:0] row_cnt_nxt;

  // Ascending packed ranges put index 0 at the MSBs, matching the flat layout.
  logic [0:N-1][0:N-1][DATA_W-1:0] mat_q;
  logic [0:N-1][DATA_W-1:0]        row_elems;

  logic accept;
  logic last_row;

  assign row_elems = in_row;
  assign Matrix    = mat_q;
  assign in_ready  = (state == LOAD) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_row  = (row_cnt == CNT_W'(N - 1));

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      mat_valid <= 1'b0;
      row_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      mat_valid <= mat_valid_nxt;
      row_cnt   <= row_cnt_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Next-state, counter and framing-error logic.
  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    frame_err_nxt = frame_err;
    case (state)
      LOAD: begin
        if (accept) begin
          // in_last only flags errors; the counter alone sets frame length.
          if (in_last != last_row) frame_err_nxt = 1'b1;
          if (last_row) begin
            row_cnt_nxt = '0;
            state_nxt   = FULL;
          end else begin
            row_cnt_nxt = row_cnt + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (mat_ack) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
    mat_valid_nxt = (state_nxt == FULL);
  end

  // Matrix storage: writes only on an accepted beat, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_q <= '0;
    end else if (accept) begin
`ifdef LOAD_TRANSPOSE_EN
      for (int c = 0; c < N; c++) begin
        mat_q[CNT_W'(c)][row_cnt] <= row_elems[CNT_W'(c)];
      end
`else
      mat_q[row_cnt] <= row_elems;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_load_64.sv
// Self-checking bench for matrix_load_64. It uses randomized and directed rows
// and checks them against an array-based matrix model.
module tb_matrix_load_64;

  localparam int N  = 64;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_row;
  logic              in_last;
  logic [N*N*DW-1:0] Matrix;
  logic              mat_valid;
  logic              mat_ack;
  logic [5:0]        row_cnt;
  logic              frame_err;

  matrix_load_64 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_last(in_last), .Matrix(Matrix),
    .mat_valid(mat_valid), .mat_ack(mat_ack), .row_cnt(row_cnt),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: element (i,j) of the expected matrix plus frame status.
  logic [DW-1:0] exp_m [N][N];
  logic [DW-1:0] rowv  [N];
  int            cnt_m  = 0;
  bit            full_m = 0;
  bit            err_m  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag);
    logic [N*N*DW-1:0] ef;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        ef[N*N*DW-1-DW*(i*N+j) -: DW] = exp_m[i][j];
    checks++;
    assert (Matrix === ef) else begin
      errors++;
      $error("FAIL %s observed_top=%0h expected_top=%0h observed_bot=%0h expected_bot=%0h",
             tag, Matrix[N*N*DW-1 -: 64], ef[N*N*DW-1 -: 64], Matrix[63:0], ef[63:0]);
    end
  endtask

  task automatic check_all();
    chk("mat_valid", 64'(mat_valid), 64'(full_m));
    chk("row_cnt",   64'(row_cnt),   64'(cnt_m));
    chk("frame_err", 64'(frame_err), 64'(err_m));
    chk("in_ready",  64'(in_ready),  64'(!full_m && !rst));
    chk_mat("matrix");
  endtask

  task automatic drive_row();
    for (int c = 0; c < N; c++) in_row[N*DW-1-DW*c -: DW] = rowv[c];
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic tick();
    bit acc;
    acc = in_valid && !full_m && !rst;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) exp_m[i][j] = '0;
      cnt_m = 0; full_m = 0; err_m = 0;
    end else if (acc) begin
      for (int c = 0; c < N; c++) begin
`ifdef LOAD_TRANSPOSE_EN
        exp_m[c][cnt_m] = in_row[N*DW-1-DW*c -: DW];
`else
        exp_m[cnt_m][c] = in_row[N*DW-1-DW*c -: DW];
`endif
      end
      if (in_last != (cnt_m == N-1)) err_m = 1;
      if (cnt_m == N-1) begin cnt_m = 0; full_m = 1; end
      else cnt_m++;
    end else if (full_m && mat_ack) begin
      full_m = 0;
    end
    #1;
    check_all();
  endtask

  task automatic do_ack();
    in_valid = 1'b0;
    mat_ack  = 1'b1;
    tick();
    mat_ack  = 1'b0;
    chk("ack_valid_low", 64'(mat_valid), 64'd0);
    chk("ack_ready_high", 64'(in_ready), 64'd1);
  endtask

  // Back-to-back beats; bad_last_at >= 0 puts in_last on that beat instead of the last.
  task automatic frame_b2b(input int mode, input int bad_last_at, input int nbeats);
    for (int r = 0; r < nbeats; r++) begin
      for (int c = 0; c < N; c++) begin
        case (mode)
          0: rowv[c] = DW'(r + 1);
          1: rowv[c] = DW'($urandom);
          default: rowv[c] = DW'(r * 64 + c);
        endcase
      end
      if (mode == 2 && r == 7) rowv[5] = 16'hFFFF;
      drive_row();
      in_valid = 1'b1;
      in_last  = (bad_last_at >= 0) ? (r == bad_last_at) : (r == N-1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int budget;
    int ii, jj;
    rst = 1'b1; in_valid = 1'b0; in_row = '0; in_last = 1'b0; mat_ack = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ready", 64'(in_ready), 64'd1);

    // Row r filled with r+1, proper in_last.
    frame_b2b(0, -1, N);
    chk("full_valid",  64'(mat_valid), 64'd1);
    chk("full_top",    64'(Matrix[N*N*DW-1 -: DW]), 64'h0001);
    chk("full_bot",    64'(Matrix[DW-1:0]), 64'h0040);
    chk("full_ready",  64'(in_ready), 64'd0);
    chk("full_err",    64'(frame_err), 64'd0);
    chk("full_cnt",    64'(row_cnt), 64'd0);

    // Held in FULL with a pending all-ones row: nothing accepted.
    for (int c = 0; c < N; c++) rowv[c] = 16'hFFFF;
    drive_row();
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_last = 1'($urandom);
      tick();
    end
    chk("hold_top", 64'(Matrix[N*N*DW-1 -: DW]), 64'h0001);
    in_last = 1'b0;
    do_ack();

    // Random 50% valid gaps, stray mat_ack in LOAD, correct in_last.
    budget = 2000;
    while (!full_m && budget > 0) begin
      for (int c = 0; c < N; c++) rowv[c] = DW'($urandom);
      drive_row();
      in_valid = 1'($urandom);
      in_last  = (cnt_m == N-1);
      mat_ack  = 1'($urandom);
      tick();
      budget--;
    end
    mat_ack = 1'b0;
    chk("rand_frame_done", 64'(full_m && budget > 0), 64'd1);
    do_ack();

    // in_last early at beat 10 and missing at beat 63.
    frame_b2b(1, 10, N);
    chk("err_frame_done", 64'(mat_valid), 64'd1);
    do_ack();
    chk("err_sticky", 64'(frame_err), 64'd1);

    // Reset mid-frame after 30 beats, then a fresh frame.
    frame_b2b(1, -1, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cnt", 64'(row_cnt), 64'd0);
    chk("midrst_mat_zero", 64'(Matrix == '0), 64'd1);
    frame_b2b(1, -1, N);
    chk("fresh_valid", 64'(mat_valid), 64'd1);
    chk("fresh_err", 64'(frame_err), 64'd0);
    do_ack();

    // Index pattern beat r element c = r*64+c, with -1 at beat 7 element 5.
    frame_b2b(2, -1, N);
`ifdef LOAD_TRANSPOSE_EN
    ii = 5; jj = 7;
    chk("pat_elem_2_3", 64'(Matrix[N*N*DW-1-DW*(2*N+3) -: DW]), 64'(3*64+2));
`else
    ii = 7; jj = 5;
    chk("pat_elem_2_3", 64'(Matrix[N*N*DW-1-DW*(2*N+3) -: DW]), 64'(2*64+3));
`endif
    chk("pat_neg_one", 64'(Matrix[N*N*DW-1-DW*(ii*N+jj) -: DW]), 64'hFFFF);
    do_ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
